// File: rtl/a2d_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_sched_pkg
//  Description : Shared types and helpers for the A2D conversion scheduler:
//                FSM state encoding, channel count and the SPI command
//                formatter used by the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package a2d_sched_pkg;

   localparam int A2D_NUM_CH = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_DEAD  = 3'd2,
      ST_READ  = 3'd3,
      ST_STORE = 3'd4
   } a2d_sched_state_t;

   // Converter command word: channel select lives in bits [13:11].
   function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_sched_rr_arb8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb8
//  Description : Combinational 8-way round-robin pick. Selects the lowest
//                pending index strictly above 'last', wrapping through 0 and
//                finally 'last' itself.
//  Ports       : pend [7:0] in  - pending request vector
//                last [2:0] in  - most recently granted index
//                gnt  [2:0] out - granted index (0 when nothing pending)
//                vld        out - a request is pending
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb8
   import a2d_sched_pkg::*;
(
   input  logic [7:0] pend,
   input  logic [2:0] last,
   output logic [2:0] gnt,
   output logic       vld
);

   logic [2:0] idx;

   // Scan last+1, last+2, ... last+8 (== last); the first hit wins.
   always_comb begin
      gnt = 3'd0;
      vld = 1'b0;
      idx = 3'd0;
      for (int i = 1; i <= A2D_NUM_CH; i++) begin
         idx = last + 3'(i);
         if (!vld && pend[idx]) begin
            gnt = idx;
            vld = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/a2d_sched.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_sched
//  Description : Conversion scheduler / arbiter for the shared 8-channel SPI
//                A2D converter. Requests come from a periodic frame timer
//                and a one-shot software port; they are granted round-robin
//                and each runs a command transaction followed by a read
//                transaction. Each result is emitted as a one-cycle tagged
//                strobe.
//  Options     : A2D_SCHED_OVR_EN - builds sticky per-channel overrun flags;
//                without it 'ovr' is tied to zero and 'ovr_clr' is ignored.
//  Ports       : clk, rst_n (async, active-low)
//                ch_en[7:0], period[PERIOD_W-1:0]   - frame timer setup
//                sw_req, sw_ch[2:0]                 - software request
//                wrt, cmd[15:0], done, rd_data[15:0] - SPI master handshake
//                res_vld, res_ch[2:0], res_data[11:0] - result strobe
//                busy, ovr[7:0], ovr_clr           - status
//  Revision    : 1.0 - initial release
// ============================================================================
module a2d_sched
   import a2d_sched_pkg::*;
#(
   parameter int PERIOD_W = 16
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          ch_en,
   input  logic [PERIOD_W-1:0] period,
   input  logic                sw_req,
   input  logic [2:0]          sw_ch,
   output logic                wrt,
   output logic [15:0]         cmd,
   input  logic                done,
   input  logic [15:0]         rd_data,
   output logic                res_vld,
   output logic [2:0]          res_ch,
   output logic [11:0]         res_data,
   output logic                busy,
   output logic [7:0]          ovr,
   input  logic                ovr_clr
);

   a2d_sched_state_t    state;
   a2d_sched_state_t    state_d;
   logic [PERIOD_W-1:0] frame_cnt;
   logic                tick;
   logic [7:0]          pend;
   logic [7:0]          req_vec;
   logic [7:0]          gnt_vec;
   logic [2:0]          last;
   logic [2:0]          cur_ch;
   logic [2:0]          gnt_ch;
   logic                gnt_vld;
   logic                grant_now;

   // Upper read bits carry no conversion data.
   logic unused_rd_hi;
   assign unused_rd_hi = ^rd_data[15:12];

   // ------------------------------------------------------------------------
   // Frame timer. Comparing with >= lets a shortened period take effect by
   // wrapping on the next cycle instead of running past the new end.
   // ------------------------------------------------------------------------
   assign tick = (period != '0) && (frame_cnt >= (period - PERIOD_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (period == '0 || tick) begin
         frame_cnt <= '0;
      end else begin
         frame_cnt <= frame_cnt + PERIOD_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Pending requests. Set wins over the grant clear so a request landing in
   // the grant cycle yields one extra conversion.
   // ------------------------------------------------------------------------
   assign req_vec   = (tick ? ch_en : 8'h00) | (sw_req ? (8'd1 << sw_ch) : 8'h00);
   assign grant_now = (state == ST_IDLE) && gnt_vld;
   assign gnt_vec   = grant_now ? (8'd1 << gnt_ch) : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 8'h00;
      end else begin
         pend <= (pend & ~gnt_vec) | req_vec;
      end
   end

   rr_arb8 u_arb (
      .pend (pend),
      .last (last),
      .gnt  (gnt_ch),
      .vld  (gnt_vld)
   );

   // ------------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // cmd tracks the grant combinationally in the grant cycle, then cur_ch
   // keeps it stable for the rest of the conversion.
   always_comb begin
      state_d = state;
      wrt     = 1'b0;
      cmd     = a2d_cmd(cur_ch);
      case (state)
         ST_IDLE: begin
            cmd = 16'h0000;
            if (gnt_vld) begin
               wrt     = 1'b1;
               cmd     = a2d_cmd(gnt_ch);
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            // Data returned with the command transaction belongs to the
            // previously selected channel and is dropped.
            if (done) state_d = ST_DEAD;
         end
         ST_DEAD: begin
            wrt     = 1'b1;
            state_d = ST_READ;
         end
         ST_READ: begin
            if (done) state_d = ST_STORE;
         end
         ST_STORE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last     <= 3'd7;
         cur_ch   <= 3'd0;
         res_ch   <= 3'd0;
         res_data <= 12'h000;
         res_vld  <= 1'b0;
      end else begin
         if (grant_now) begin
            last   <= gnt_ch;
            cur_ch <= gnt_ch;
         end
         if (state == ST_READ && done) begin
            res_ch   <= cur_ch;
            res_data <= rd_data[11:0];
         end
         res_vld <= (state == ST_STORE);
      end
   end

   // ------------------------------------------------------------------------
   // Overrun flags: a request for a channel that is already queued or is the
   // one currently converting.
   // ------------------------------------------------------------------------
`ifdef A2D_SCHED_OVR_EN
   logic [7:0] cur_vec;
   logic [7:0] ovr_set;
   logic [7:0] ovr_q;

   assign cur_vec = busy ? (8'd1 << cur_ch) : 8'h00;
   assign ovr_set = req_vec & (pend | cur_vec);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 8'h00;
      end else begin
         ovr_q <= (ovr_clr ? 8'h00 : ovr_q) | ovr_set;
      end
   end

   assign ovr = ovr_q;
`else
   logic unused_ovr_clr;
   assign unused_ovr_clr = ovr_clr;
   assign ovr = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_a2d_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a2d_sched
//  Description : Directed self-checking bench for a2d_sched with a simple
//                behavioural SPI master (done 34 cycles after wrt,
//                rd_data = {4'h0, ch, 9'h0AB}).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_sched;
    import a2d_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ch_en;
    logic [15:0] period;
    logic        sw_req;
    logic [2:0]  sw_ch;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic        res_vld;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic        busy;
    logic [7:0]  ovr;
    logic        ovr_clr;

    int total = 0;
    int bad   = 0;

`ifdef A2D_SCHED_OVR_EN
    localparam logic [7:0] C_OVR3_EXP = 8'h08;
`else
    localparam logic [7:0] C_OVR3_EXP = 8'h00;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    a2d_sched #(.PERIOD_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .period   (period),
        .sw_req   (sw_req),
        .sw_ch    (sw_ch),
        .wrt      (wrt),
        .cmd      (cmd),
        .done     (done),
        .rd_data  (rd_data),
        .res_vld  (res_vld),
        .res_ch   (res_ch),
        .res_data (res_data),
        .busy     (busy),
        .ovr      (ovr),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural SPI master. Extra done pulses are requested by toggling
    // spur_tog (immediate) or dbl_arm (right after the next natural done).
    // ------------------------------------------------------------------------
    int         spi_cnt    = 0;
    logic [2:0] spi_ch     = 3'd0;
    bit         spur_tog   = 1'b0;
    bit         spur_seen  = 1'b0;
    bit         dbl_arm    = 1'b0;
    bit         dbl_seen   = 1'b0;
    bit         extra_pend = 1'b0;

    initial begin
        done    = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (!rst_n) begin
                spi_cnt    = 0;
                extra_pend = 1'b0;
            end else begin
                if (extra_pend) begin
                    done       = 1'b1;
                    extra_pend = 1'b0;
                end
                if (spur_tog != spur_seen) begin
                    done      = 1'b1;
                    spur_seen = spur_tog;
                end
                if (spi_cnt > 0) begin
                    spi_cnt--;
                    if (spi_cnt == 0) begin
                        done    = 1'b1;
                        rd_data = {4'h0, spi_ch, 9'h0AB};
                        if (dbl_arm != dbl_seen) begin
                            extra_pend = 1'b1;
                            dbl_seen   = dbl_arm;
                        end
                    end
                end
                if (wrt) begin
                    spi_cnt = 34;
                    spi_ch  = cmd[13:11];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic sw_pulse(input logic [2:0] ch);
        @(negedge clk);
        sw_req = 1'b1;
        sw_ch  = ch;
        @(negedge clk);
        sw_req = 1'b0;
    endtask

    task automatic wait_state(input a2d_sched_state_t st, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (dut.state === st) ok = 1'b1;
        end
    endtask

    task automatic check_result(input logic [2:0] exp_ch);
        bit          got;
        logic [2:0]  rch;
        logic [11:0] rdat;
        logic [11:0] exp_data;
        got      = 1'b0;
        rch      = 3'bxxx;
        rdat     = 12'hxxx;
        exp_data = {exp_ch, 9'h0AB};
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (res_vld === 1'b1) begin
                got  = 1'b1;
                rch  = res_ch;
                rdat = res_data;
            end
        end
        chk("res_got", got, 1'b1);
        chk("res_ch", rch, exp_ch);
        chk("res_data", rdat, exp_data);
    endtask

    logic [2:0] order [3] = '{3'd0, 3'd4, 3'd5};

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        bit ok;
        int n_wrt;
        int n_res;
        logic [2:0] seen_ch;

        rst_n   = 1'b0;
        ch_en   = 8'h00;
        period  = 16'd0;
        sw_req  = 1'b0;
        sw_ch   = 3'd0;
        ovr_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrt", wrt, 1'b0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_res_vld", res_vld, 1'b0);
        chk("rst_res_ch", res_ch, 3'd0);
        chk("rst_res_data", res_data, 12'h000);
        chk("rst_ovr", ovr, 8'h00);
        chk("rst_last", dut.last, 3'd7);
        chk("rst_pend", dut.pend, 8'h00);

        // Frame-driven conversions: ch0, ch4, ch5 repeating
        rst_n  = 1'b1;
        ch_en  = 8'h31;
        period = 16'd200;
        for (int k = 0; k < 6; k++) begin
            check_result(order[k % 3]);
        end
        period = 16'd0;
        ch_en  = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && dut.pend === 8'h00) ok = 1'b1;
        end
        chk("drain_idle", ok, 1'b1);
        repeat (3) @(negedge clk);

        // Grant latency, cmd format, wrap-around and result latency
        sw_pulse(3'd6);
        chk("grant_wrt", wrt, 1'b1);
        chk("grant_cmd", cmd, 16'h3000);
        chk("grant_busy", busy, 1'b0);
        sw_pulse(3'd2);
        sw_pulse(3'd6);
        wait_state(ST_STORE, 200, ok);
        chk("store_seen", ok, 1'b1);
        chk("store_cmd_held", cmd, 16'h3000);
        chk("lat_vld_early", res_vld, 1'b0);
        @(negedge clk);
        chk("lat_vld", res_vld, 1'b1);
        chk("lat_ch", res_ch, 3'd6);
        check_result(3'd2);
        check_result(3'd6);
        repeat (3) @(negedge clk);

        // Overrun: re-request ch3 while ch3 converts
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_cleared", ovr, 8'h00);
        sw_pulse(3'd3);
        repeat (10) @(negedge clk);
        sw_pulse(3'd3);
        chk("ovr3", ovr, C_OVR3_EXP);
        check_result(3'd3);
        check_result(3'd3);
        n_wrt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (wrt === 1'b1) n_wrt++;
        end
        chk("ch3_quiet", n_wrt, 0);

        // Spurious done in IDLE and in DEAD
        spur_tog = ~spur_tog;
        repeat (3) @(negedge clk);
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_state", dut.state, ST_IDLE);
        dbl_arm = ~dbl_arm;
        sw_pulse(3'd1);
        wait_state(ST_DEAD, 100, ok);
        chk("dead_seen", ok, 1'b1);
        @(negedge clk);
        chk("spur_dead_state", dut.state, ST_READ);
        check_result(3'd1);
        repeat (3) @(negedge clk);

        // Reset during READ
        sw_pulse(3'd4);
        wait_state(ST_READ, 100, ok);
        chk("read_seen", ok, 1'b1);
        sw_pulse(3'd6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pend", dut.pend, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        n_res = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (res_vld === 1'b1) n_res++;
        end
        chk("midrst_no_res", n_res, 0);
        sw_pulse(3'd5);
        check_result(3'd5);
        repeat (5) @(negedge clk);

        // period == 0: single software conversion on ch7 only
        ch_en   = 8'hFF;
        period  = 16'd0;
        n_wrt   = 0;
        n_res   = 0;
        seen_ch = 3'd0;
        @(negedge clk);
        sw_req = 1'b1;
        sw_ch  = 3'd7;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sw_req = 1'b0;
            if (wrt === 1'b1) n_wrt++;
            if (res_vld === 1'b1) begin
                n_res++;
                seen_ch = res_ch;
            end
        end
        chk("p0_results", n_res, 1);
        chk("p0_wrts", n_wrt, 2);
        chk("p0_ch", seen_ch, 3'd7);
        chk("p0_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
